// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath width, reset/bubble defaults and the
// instruction-fetch state encoding.
package cpu_defs;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  // Instructions are word aligned; the low two bits of any redirect are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in
// flight and presents (if_pc, if_inst, if_valid) to the IF/ID register.
module if_fetch
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_valid
);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] req_pc_reg, req_pc_next;
  logic            kill_reg, kill_next;
  logic [XLEN-1:0] hold_inst_reg, hold_inst_next;
  logic [XLEN-1:0] hold_pc_reg, hold_pc_next;
  logic [XLEN-1:0] if_pc_reg, if_pc_next;
  logic [XLEN-1:0] if_inst_reg, if_inst_next;
  logic            if_valid_reg, if_valid_next;

  logic            deliver;
  logic [XLEN-1:0] del_pc;
  logic [XLEN-1:0] del_inst;
  logic [XLEN-1:0] br_pc;

  assign br_pc = align_pc(br_target);

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    req_pc_next    = req_pc_reg;
    kill_next      = kill_reg;
    hold_inst_next = hold_inst_reg;
    hold_pc_next   = hold_pc_reg;
    deliver        = 1'b0;
    del_pc         = hold_pc_reg;
    del_inst       = hold_inst_reg;

    case (state_reg)
      IDLE: begin
        state_next = REQ;
        if (br_taken) pc_next = br_pc;
      end
      REQ: begin
        if (imem_gnt) begin
          state_next  = WAIT;
          req_pc_next = pc_reg;
          // The granted request belongs to the old path; its response must be dropped.
          if (br_taken) kill_next = 1'b1;
        end
        if (br_taken) pc_next = br_pc;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_next = REQ;
          kill_next  = 1'b0;
          if (br_taken) begin
            pc_next = br_pc;
          end else if (!kill_reg) begin
            if (!stall) begin
              deliver  = 1'b1;
              del_pc   = req_pc_reg;
              del_inst = imem_rdata;
              pc_next  = req_pc_reg + XLEN'(4);
            end else begin
              state_next     = HOLD;
              hold_inst_next = imem_rdata;
              hold_pc_next   = req_pc_reg;
            end
          end
        end else if (br_taken) begin
          kill_next = 1'b1;
          pc_next   = br_pc;
        end
      end
      HOLD: begin
        if (br_taken) begin
          state_next = REQ;
          pc_next    = br_pc;
        end else if (!stall) begin
          state_next = REQ;
          deliver    = 1'b1;
          pc_next    = hold_pc_reg + XLEN'(4);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A redirect flushes even under stall; otherwise stall freezes the outputs.
  always_comb begin
    if_pc_next    = if_pc_reg;
    if_inst_next  = if_inst_reg;
    if_valid_next = if_valid_reg;
    if (br_taken) begin
      if_valid_next = 1'b0;
      if_inst_next  = NOP_INST;
    end else if (deliver) begin
      if_valid_next = 1'b1;
      if_pc_next    = del_pc;
      if_inst_next  = del_inst;
    end else if (!stall) begin
      if_valid_next = 1'b0;
      if_inst_next  = NOP_INST;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      req_pc_reg    <= '0;
      kill_reg      <= 1'b0;
      hold_inst_reg <= '0;
      hold_pc_reg   <= '0;
      if_pc_reg     <= '0;
      if_inst_reg   <= NOP_INST;
      if_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      req_pc_reg    <= req_pc_next;
      kill_reg      <= kill_next;
      hold_inst_reg <= hold_inst_next;
      hold_pc_reg   <= hold_pc_next;
      if_pc_reg     <= if_pc_next;
      if_inst_reg   <= if_inst_next;
      if_valid_reg  <= if_valid_next;
    end
  end

  assign imem_req  = (state_reg == REQ);
  assign imem_addr = pc_reg;
  assign if_pc     = if_pc_reg;
  assign if_inst   = if_inst_reg;
  assign if_valid  = if_valid_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-cycle vector table plus a hand-written
// asynchronous-reset sequence; a small imem responder answers granted requests.
module tb_if_fetch;

  localparam logic [31:0] RPC  = 32'hFFFF_FFFC;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  if_fetch #(
    .RESET_PC(RPC),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_valid   (if_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  int          errors = 0;
  int          checks = 0;
  int          rsp_lat = 1;
  int          rsp_cnt = 0;
  logic        rsp_pend = 1'b0;
  logic [31:0] rsp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
    chk({tag, " imem_req"},  {31'b0, imem_req}, {31'b0, e_req});
    chk({tag, " imem_addr"}, imem_addr, e_addr);
    chk({tag, " if_valid"},  {31'b0, if_valid}, {31'b0, e_valid});
    chk({tag, " if_pc"},     if_pc, e_pc);
    chk({tag, " if_inst"},   if_inst, e_inst);
    $display("%s: req=%b addr=%h valid=%b pc=%h inst=%h",
             tag, imem_req, imem_addr, if_valid, if_pc, if_inst);
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  // The responder returns addr^SALT rsp_lat cycles after an accepted request.
  task automatic step();
    logic        acc;
    logic [31:0] acc_addr;
    acc      = imem_req && imem_gnt && rst;
    acc_addr = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (acc) begin
      rsp_pend = 1'b1;
      rsp_cnt  = rsp_lat;
      rsp_data = acc_addr ^ SALT;
    end
    if (rsp_pend) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = rsp_data;
        rsp_pend    = 1'b0;
      end
    end
  endtask

  task automatic add(input logic gnt, input logic stl, input logic br, input logic [31:0] tgt,
                     input int lat, input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.gnt = gnt; v.stall = stl; v.br = br; v.tgt = tgt; v.lat = lat;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst;
    vecs.push_back(v);
  endtask

  initial begin
    rst         = 1'b0;
    stall       = 1'b0;
    br_taken    = 1'b0;
    br_target   = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // Sequential fetch from RESET_PC, wrapping past the top of memory.
    add(1, 0, 0, 32'h0,   1, 1, RPC,          0, 32'h0,   32'h0);
    add(1, 0, 0, 32'h0,   1, 0, RPC,          0, 32'h0,   32'h0);
    add(1, 0, 0, 32'h0,   1, 1, 32'h0,        1, RPC,     32'h5A5A_FFFC);
    add(1, 0, 0, 32'h0,   1, 0, 32'h0,        0, RPC,     32'h0);
    add(1, 0, 0, 32'h0,   1, 1, 32'h4,        1, 32'h0,   32'hA5A5_0000);
    // Stall across the response for addr 4: outputs frozen, no new request.
    add(1, 1, 0, 32'h0,   1, 0, 32'h4,        1, 32'h0,   32'hA5A5_0000);
    add(1, 1, 0, 32'h0,   1, 0, 32'h4,        1, 32'h0,   32'hA5A5_0000);
    add(1, 1, 0, 32'h0,   1, 0, 32'h4,        1, 32'h0,   32'hA5A5_0000);
    add(1, 1, 0, 32'h0,   1, 0, 32'h4,        1, 32'h0,   32'hA5A5_0000);
    add(1, 0, 0, 32'h0,   1, 1, 32'h8,        1, 32'h4,   32'hA5A5_0004);
    // Redirect while waiting on addr 8 (response arrives one cycle later).
    add(1, 0, 0, 32'h0,   2, 0, 32'h8,        0, 32'h4,   32'h0);
    add(1, 0, 1, 32'h100, 1, 0, 32'h100,      0, 32'h4,   32'h0);
    add(1, 0, 0, 32'h0,   1, 1, 32'h100,      0, 32'h4,   32'h0);
    add(1, 0, 0, 32'h0,   1, 0, 32'h100,      0, 32'h4,   32'h0);
    add(1, 0, 0, 32'h0,   1, 1, 32'h104,      1, 32'h100, 32'hA5A5_0100);
    // Redirect coincident with grant and stall; target low bits dropped.
    add(1, 1, 1, 32'h103, 1, 0, 32'h100,      0, 32'h100, 32'h0);
    add(1, 0, 0, 32'h0,   1, 1, 32'h100,      0, 32'h100, 32'h0);
    add(1, 0, 0, 32'h0,   1, 0, 32'h100,      0, 32'h100, 32'h0);
    add(1, 0, 0, 32'h0,   1, 1, 32'h104,      1, 32'h100, 32'hA5A5_0100);
    // Grant withheld for five cycles.
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 32'h0, 1, 1, 32'h104,      0, 32'h100, 32'h0);
    add(1, 0, 0, 32'h0,   1, 0, 32'h104,      0, 32'h100, 32'h0);
    add(1, 0, 0, 32'h0,   1, 1, 32'h108,      1, 32'h104, 32'hA5A5_0104);
    // Enter WAIT with a slow response; reset hits before it returns.
    add(1, 0, 0, 32'h0,   5, 0, 32'h108,      0, 32'h104, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, RPC, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      imem_gnt  = vecs[i].gnt;
      stall     = vecs[i].stall;
      br_taken  = vecs[i].br;
      br_target = vecs[i].tgt;
      rsp_lat   = vecs[i].lat;
      step();
      chk_all($sformatf("row%0d", i + 1), vecs[i].e_req, vecs[i].e_addr,
              vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst);
    end

    // Asynchronous reset mid-WAIT: outputs clear before any clock edge.
    stall    = 1'b0;
    br_taken = 1'b0;
    rsp_lat  = 1;
    rst      = 1'b0;
    rsp_pend = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, RPC, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    // Stale response during IDLE must be ignored.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    chk_all("post_rst_idle", 1'b1, RPC, 1'b0, 32'h0, 32'h0);
    imem_gnt = 1'b1;
    step();
    chk_all("post_rst_gnt", 1'b0, RPC, 1'b0, 32'h0, 32'h0);
    step();
    chk_all("post_rst_deliver", 1'b1, 32'h0, 1'b1, RPC, 32'h5A5A_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
